// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for mem_access_unit.
//   OP_*  : request operation codes (op[3]=store, op[2]=unsigned, op[1:0]=size)
//   SEL_* : legal RAM byte-select patterns
//   SZ_*  : access size field values
//   state_e : access FSM states
//   op_known() : true for the eight defined operation codes
package mau_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_load_extract.sv
// mau_load_extract: combinational load lane select and sign/zero extension.
//   size    in  2   access size (SZ_B / SZ_H / SZ_W)
//   uns     in  1   1 = zero-extend, 0 = sign-extend
//   addr_lo in  2   byte offset within the word
//   word    in  32  raw RAM word
//   data    out 32  extended load value
module mau_load_extract
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = '0;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    data = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    data = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side load/store initiator for the byte-selectable 1024x32 RAM.
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_op/req_addr/req_wdata : request handshake from MEM stage
//   resp_valid/resp_rdata/resp_err                : one-cycle response pulse
//   mem_we/mem_sel/mem_ld/mem_addr/mem_din/mem_dout : RAM strobes and data
// Build option: define MAU_ALIGN_TRAP_EN to trap misaligned half/word accesses;
// otherwise the low address bits are ignored for those sizes.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic              mem_ld,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  state_e            state, state_nxt;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              known, is_load, is_store, misaligned, err, go;
  logic [3:0]        lane_sel;
  logic [31:0]       lane_din;
  logic [31:0]       ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    req_ready = 1'b0;
    state_nxt = state;
    if (!rst && (state == ST_IDLE || state == ST_RESP)) req_ready = 1'b1;
    accept = req_valid & req_ready;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    known    = op_known(op_q);
    is_store = known & op_q[3];
    is_load  = known & ~op_q[3];
`ifdef MAU_ALIGN_TRAP_EN
    misaligned = known && ((op_q[1:0] == SZ_H && addr_q[0]) ||
                           (op_q[1:0] == SZ_W && addr_q[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    err = ~known | misaligned;
    go  = (state == ST_ACCESS) && !err;
  end

  // Half/word lane choice only looks at addr[1] / nothing, which is what makes
  // the low address bits drop out in the non-trap build.
  always_comb begin
    lane_sel = '0;
    lane_din = '0;
    case (op_q[1:0])
      SZ_B: begin
        lane_sel = SEL_B0 << addr_q[1:0];
        lane_din = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        lane_sel = addr_q[1] ? SEL_H1 : SEL_H0;
        lane_din = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_sel = SEL_W;
        lane_din = wdata_q;
      end
    endcase
  end

  always_comb begin
    mem_we   = go & is_store;
    mem_ld   = go & is_load;
    mem_sel  = go ? lane_sel : '0;
    mem_addr = go ? addr_q[ADDR_W-1:2] : '0;
    mem_din  = (go & is_store) ? lane_din : '0;
  end

  mau_load_extract u_extract (
    .size    (op_q[1:0]),
    .uns     (op_q[2]),
    .addr_lo (addr_q[1:0]),
    .word    (mem_dout),
    .data    (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state == ST_ACCESS);
      resp_err   <= (state == ST_ACCESS) && err;
      resp_rdata <= (go && is_load) ? ld_data : '0;
    end
  end

endmodule
